histo_readout: RTL

- Downstream consumer of the trigger-sync/histogram stage.
- On a start command, steps the histogram-select output through every channel and waits for the selected words to settle.
- Snapshots the 8 histogram words for each channel and streams them as a framed byte stream over a valid/ready byte interface to the host link.
- Can issue a histogram-clear pulse after a complete dump. Runs in the clk_adc domain, the same domain as the histogram producer.

---
 rtl/histo_readout_pkg.sv | 29 ++
 rtl/histo_readout_byte_tx.sv | 33 +++
 rtl/histo_readout.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/histo_readout_pkg.sv
// histo_readout_pkg: shared states, header byte and frame-size helpers for the histogram readout
package histo_readout_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_SEL,
        S_CAP,
        S_CHB,
        S_DATA,
        S_CSUM,
        S_CLR,
        S_FIN
    } state_e;

    localparam logic [7:0] HDR = 8'hA5;

    localparam int DEF_NCHAN = 16;
    localparam int DEF_NHIST = 8;
    localparam int DEF_WORDW = 32;

    localparam int BYTES_PER_CH = DEF_NHIST * DEF_WORDW / 8;

    // header + per channel (channel byte + payload) + checksum
    function automatic int frame_len(input int nchan, input int bpc);
        return nchan * (bpc + 1) + 2;
    endfunction

endpackage

// File: rtl/histo_readout_byte_tx.sv
// histo_byte_tx: one-entry valid/ready holding register for the outgoing byte stream
module histo_byte_tx (
    input  logic       clk,
    input  logic       nrst,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       tx_ready_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    output logic       acc_o
);

    logic [7:0] data_q;
    logic       valid_q;

    assign tx_data_o  = data_q;
    assign tx_valid_o = valid_q;
    assign acc_o      = valid_q & tx_ready_i;

    // a load may coincide with acceptance so back-to-back bytes keep valid high
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (acc_o) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/histo_readout.sv
// histo_readout: sweeps histogram channels, snapshots their words and streams a checksummed byte frame
module histo_readout
    import histo_readout_pkg::*;
#(
    parameter int         NCHAN     = DEF_NCHAN,
    parameter int         NHIST     = DEF_NHIST,
    parameter int         WORDW     = DEF_WORDW,
    parameter int         SETTLE    = 3,
    parameter int         CLRCYCLES = 4,
    parameter logic [7:0] HDR_BYTE  = HDR
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   start,
    input  logic                   clear_after,
    output logic [7:0]             histostosend,
    input  logic [NHIST*WORDW-1:0] histosin,
    output logic                   resethist,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int TOT = NHIST * WORDW;
    localparam int BPC = TOT / 8;
    localparam int CW  = 16;

    localparam logic [CW-1:0] SET_LAST  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLRCYCLES - 1);
    localparam logic [CW-1:0] BYTE_LAST = CW'(BPC - 1);
    localparam logic [7:0]    CH_LAST   = 8'(NCHAN - 1);

    state_e          state_q, state_d;
    logic [7:0]      sel_q, sel_d;
    logic [7:0]      csum_q, csum_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            clr_q, clr_d;
    logic            loaded_q, loaded_d;
    logic            rdy_q;
    logic [TOT-1:0]  snap_q, snap_d, cap_w;
    logic            load;
    logic [7:0]      ld_data;
    logic            acc;

    assign histostosend = sel_q;
    assign resethist    = (state_q == S_CLR);
    assign done         = (state_q == S_FIN);
    assign busy         = (state_q != S_IDLE) && (state_q != S_FIN);

    histo_byte_tx u_tx (
        .clk        (clk),
        .nrst       (nrst),
        .load_i     (load),
        .data_i     (ld_data),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .acc_o      (acc)
    );

    // reorder words so the first byte to send sits at the top of the snapshot
    always_comb begin
        cap_w = '0;
        for (int k = 0; k < NHIST; k++)
            cap_w[TOT-1-k*WORDW -: WORDW] = histosin[k*WORDW +: WORDW];
    end

    // state and datapath registers; rdy_q keeps a start coinciding with reset release from being taken
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            sel_q    <= 8'h00;
            csum_q   <= 8'h00;
            cnt_q    <= '0;
            clr_q    <= 1'b0;
            loaded_q <= 1'b0;
            rdy_q    <= 1'b0;
            snap_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            csum_q   <= csum_d;
            cnt_q    <= cnt_d;
            clr_q    <= clr_d;
            loaded_q <= loaded_d;
            rdy_q    <= 1'b1;
            snap_q   <= snap_d;
        end
    end

    // next-state logic; loaded_q marks that the current state's byte is already in the tx register
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        csum_d   = csum_q;
        cnt_d    = cnt_q;
        clr_d    = clr_q;
        loaded_d = loaded_q;
        snap_d   = snap_q;
        load     = 1'b0;
        ld_data  = 8'h00;
        case (state_q)
            S_IDLE: begin
                sel_d = 8'h00;
                if (start && rdy_q) begin
                    clr_d    = clear_after;
                    csum_d   = 8'h00;
                    loaded_d = 1'b0;
                    state_d  = S_HDR;
                end
            end
            S_HDR: begin
                if (!loaded_q) begin
                    load     = 1'b1;
                    ld_data  = HDR_BYTE;
                    loaded_d = 1'b1;
                end else if (acc) begin
                    loaded_d = 1'b0;
                    sel_d    = 8'h00;
                    cnt_d    = '0;
                    state_d  = S_SEL;
                end
            end
            S_SEL: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == SET_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CAP;
                end
            end
            S_CAP: begin
                snap_d  = cap_w;
                state_d = S_CHB;
            end
            S_CHB: begin
                if (!loaded_q) begin
                    load     = 1'b1;
                    ld_data  = sel_q;
                    loaded_d = 1'b1;
                end else if (acc) begin
                    csum_d  = csum_q + tx_data;
                    load    = 1'b1;
                    ld_data = snap_q[TOT-1 -: 8];
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (acc) begin
                    csum_d = csum_q + tx_data;
                    snap_d = snap_q << 8;
                    if (cnt_q == BYTE_LAST) begin
                        loaded_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = (sel_q == CH_LAST) ? S_CSUM : S_SEL;
                        sel_d    = (sel_q == CH_LAST) ? sel_q : sel_q + 8'd1;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        load    = 1'b1;
                        ld_data = snap_q[TOT-9 -: 8];
                    end
                end
            end
            S_CSUM: begin
                if (!loaded_q) begin
                    load     = 1'b1;
                    ld_data  = csum_q;
                    loaded_d = 1'b1;
                end else if (acc) begin
                    loaded_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = clr_q ? S_CLR : S_FIN;
                end
            end
            S_CLR: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                sel_d   = 8'h00;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
